// File: rtl/uart_client_link.sv
// Client-side link controller: turns host commands into signal/payload byte sequences on the UART
// and tracks the Device's grant and streaming state from its acknowledgements.
module uart_client_link #(
  parameter int unsigned CLK_TIMEOUT = 1000000,
  parameter logic [3:0]  CRC_SIG     = 4'h1,
  parameter logic [3:0]  RGC_SIG     = 4'h2,
  parameter logic [3:0]  ACK_SIG     = 4'h3,
  parameter logic [3:0]  BOS_SIG     = 4'h4,
  parameter logic [3:0]  EOS_SIG     = 4'h5,
  parameter logic [3:0]  DAT_SIG     = 4'h6,
  parameter logic [3:0]  KEY_SIG     = 4'h7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       done,
  output logic       error,
  output logic       granted,
  output logic       streaming,
  output logic       tx_en,
  output logic [7:0] tx_byte,
  input  logic       tx_complete,
  input  logic [7:0] rx_byte,
  input  logic       rx_complete,
  output logic       rx_ack
);

  localparam int unsigned CntW = $clog2(CLK_TIMEOUT) + 1;

  localparam logic [2:0] CmdKey = 3'd0;
  localparam logic [2:0] CmdCrc = 3'd1;
  localparam logic [2:0] CmdBos = 3'd2;
  localparam logic [2:0] CmdDat = 3'd3;
  localparam logic [2:0] CmdEos = 3'd4;

  typedef enum logic [2:0] {
    StIdle, StLoad, StTrig, StTxWait, StRxWait, StRxAck, StDone, StFail
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [7:0]      data_q, data_d;
  logic            step_q, step_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            rx_ack_q, rx_ack_d;
  logic            rx_hold_q, rx_hold_d;
  logic [3:0]      rx_nib_q, rx_nib_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            granted_q, granted_d;
  logic            streaming_q, streaming_d;

  logic       rx_take;
  logic       timeout;
  logic       illegal;
  logic [3:0] sig;
  logic [3:0] expect_nib;
  logic       unused_rx_low;

  assign unused_rx_low = ^rx_byte[3:0];

  // rx_hold_q marks a byte already acknowledged while rx_complete is still high.
  assign rx_take    = rx_complete && !rx_hold_q;
  assign timeout    = (cnt_q == CntW'(CLK_TIMEOUT - 1));
  assign expect_nib = (cmd_q == CmdCrc) ? RGC_SIG : ACK_SIG;
  assign illegal    = (cmd > CmdEos) ||
                      (((cmd == CmdDat) || (cmd == CmdBos)) && !granted_q) ||
                      ((cmd == CmdCrc) && granted_q) ||
                      ((cmd == CmdBos) && streaming_q);

  always_comb begin
    sig = EOS_SIG;
    case (cmd_q)
      CmdKey:  sig = KEY_SIG;
      CmdCrc:  sig = CRC_SIG;
      CmdBos:  sig = BOS_SIG;
      CmdDat:  sig = DAT_SIG;
      default: sig = EOS_SIG;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    step_d      = step_q;
    tx_byte_d   = tx_byte_q;
    rx_ack_d    = 1'b0;
    rx_hold_d   = rx_hold_q && rx_complete;
    rx_nib_d    = rx_nib_q;
    cnt_d       = cnt_q;
    granted_d   = granted_q;
    streaming_d = streaming_q;

    // Any fresh byte is acknowledged once; outside RXWAIT it is simply dropped.
    if (rx_take && (state_q != StRxAck)) begin
      rx_ack_d  = 1'b1;
      rx_hold_d = 1'b1;
      rx_nib_d  = rx_byte[7:4];
    end

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_d   = cmd;
          data_d  = cmd_data;
          step_d  = 1'b0;
          state_d = illegal ? StFail : StLoad;
        end
      end
      StLoad: begin
        tx_byte_d = step_q ? data_q : {sig, 4'b0000};
        state_d   = StTrig;
      end
      StTrig: state_d = StTxWait;
      StTxWait: begin
        if (tx_complete) begin
          if (step_q) begin
            state_d = StDone;
          end else if (cmd_q == CmdKey) begin
            step_d  = 1'b1;
            state_d = StLoad;
          end else if (cmd_q == CmdEos) begin
            granted_d   = 1'b0;
            streaming_d = 1'b0;
            state_d     = StDone;
          end else begin
            cnt_d   = '0;
            state_d = StRxWait;
          end
        end
      end
      StRxWait: begin
        if (timeout) begin
          state_d = StFail;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (rx_take) state_d = StRxAck;
        end
      end
      StRxAck: begin
        if (timeout) begin
          state_d = StFail;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (rx_nib_q == expect_nib) begin
            if (cmd_q == CmdCrc) begin
              granted_d = 1'b1;
              state_d   = StDone;
            end else if (cmd_q == CmdBos) begin
              streaming_d = 1'b1;
              state_d     = StDone;
            end else begin
              step_d  = 1'b1;
              state_d = StLoad;
            end
          end else if (!rx_complete) begin
            state_d = StRxWait;
          end
        end
      end
      StDone:  state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      data_q      <= '0;
      step_q      <= 1'b0;
      tx_byte_q   <= '0;
      rx_ack_q    <= 1'b0;
      rx_hold_q   <= 1'b0;
      rx_nib_q    <= '0;
      cnt_q       <= '0;
      granted_q   <= 1'b0;
      streaming_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      step_q      <= step_d;
      tx_byte_q   <= tx_byte_d;
      rx_ack_q    <= rx_ack_d;
      rx_hold_q   <= rx_hold_d;
      rx_nib_q    <= rx_nib_d;
      cnt_q       <= cnt_d;
      granted_q   <= granted_d;
      streaming_q <= streaming_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign done      = (state_q == StDone);
  assign error     = (state_q == StFail);
  assign tx_en     = (state_q != StTrig);
  assign tx_byte   = tx_byte_q;
  assign rx_ack    = rx_ack_q;
  assign granted   = granted_q;
  assign streaming = streaming_q;

endmodule

// File: tb/tb_uart_client_link.sv
// Directed bench for uart_client_link: scripted UART Tx/Rx device responses, hand-computed bytes.
module tb_uart_client_link;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, done, error, granted, streaming, tx_en, rx_ack;
  logic [7:0] tx_byte;
  logic       tx_complete = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_complete = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_trig = 0;
  int n_ack = 0;

  always #5 clock = ~clock;

  uart_client_link #(.CLK_TIMEOUT(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .done        (done),
    .error       (error),
    .granted     (granted),
    .streaming   (streaming),
    .tx_en       (tx_en),
    .tx_byte     (tx_byte),
    .tx_complete (tx_complete),
    .rx_byte     (rx_byte),
    .rx_complete (rx_complete),
    .rx_ack      (rx_ack)
  );

  // Pre-edge values: each output cycle is counted exactly once.
  always @(posedge clock) begin
    if (tx_en === 1'b0) n_trig++;
    if (rx_ack === 1'b1) n_ack++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_trig(output logic [7:0] b);
    b = 8'hxx;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tx_en === 1'b0) begin
        b = tx_byte;
        return;
      end
    end
  endtask

  // Device Tx side: finishes the byte a couple of cycles after the trigger.
  task automatic send_done();
    tick();
    tick();
    tx_complete = 1'b1;
    tick();
    tx_complete = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_byte     = b;
    rx_complete = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rx_ack === 1'b1) break;
    end
    rx_complete = 1'b0;
    tick();
  endtask

  task automatic wait_resp(output logic [1:0] kind);
    kind = 2'b00;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1 || error === 1'b1) begin
        kind = {done, error};
        return;
      end
      tick();
    end
  endtask

  logic [7:0] b;
  logic [1:0] kind;
  int         t0, a0, n;

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_tx_en", tx_en, 1);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_rx_ack", rx_ack, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_granted", granted, 0);
    check("rst_streaming", streaming, 0);
    reset = 1'b1;
    tick();

    // KEY 0x41: signal byte then key code, no response expected.
    issue(3'd0, 8'h41);
    wait_trig(b); check("key_sig", b, 8'h70);
    send_done();
    wait_trig(b); check("key_data", b, 8'h41);
    send_done();
    wait_resp(kind); check("key_resp", kind, 2'b10);
    check("key_granted", granted, 0);
    tick();

    // CRC, Device grants with RGC.
    a0 = n_ack;
    issue(3'd1, 8'h00);
    wait_trig(b); check("crc_sig", b, 8'h10);
    send_done();
    rx_send(8'h20);
    wait_resp(kind); check("crc_resp", kind, 2'b10);
    check("crc_granted", granted, 1);
    tick(); tick();
    check("crc_acks", n_ack - a0, 1);

    // DAT 0xA5: first reply is not an ACK and must be skipped.
    a0 = n_ack;
    issue(3'd3, 8'hA5);
    wait_trig(b); check("dat_sig", b, 8'h60);
    send_done();
    rx_send(8'h55);
    rx_send(8'h30);
    wait_trig(b); check("dat_data", b, 8'hA5);
    send_done();
    wait_resp(kind); check("dat_resp", kind, 2'b10);
    tick(); tick();
    check("dat_acks", n_ack - a0, 2);

    // BOS then a second BOS while streaming.
    issue(3'd2, 8'h00);
    wait_trig(b); check("bos_sig", b, 8'h40);
    send_done();
    rx_send(8'h30);
    wait_resp(kind); check("bos_resp", kind, 2'b10);
    check("bos_streaming", streaming, 1);
    tick();
    t0 = n_trig;
    issue(3'd2, 8'h00);
    wait_resp(kind); check("bos2_resp", kind, 2'b01);
    tick(); tick();
    check("bos2_no_trig", n_trig - t0, 0);

    // EOS drops grant and streaming.
    issue(3'd4, 8'h00);
    wait_trig(b); check("eos_sig", b, 8'h50);
    send_done();
    wait_resp(kind); check("eos_resp", kind, 2'b10);
    check("eos_granted", granted, 0);
    check("eos_streaming", streaming, 0);
    tick();

    // Rejected commands: DAT without grant, illegal opcode 6.
    t0 = n_trig;
    issue(3'd3, 8'h11);
    wait_resp(kind); check("dat_nogrant_resp", kind, 2'b01);
    tick();
    issue(3'd6, 8'h00);
    wait_resp(kind); check("illegal_resp", kind, 2'b01);
    tick(); tick();
    check("reject_no_trig", n_trig - t0, 0);

    // CRC with no reply: error 16 cycles after entering RXWAIT.
    issue(3'd1, 8'h00);
    wait_trig(b); check("to_sig", b, 8'h10);
    send_done();
    n = 0;
    while (error !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("to_cycles", n, 16);
    check("to_granted", granted, 0);
    tick();
    check("to_cmd_ready", cmd_ready, 1);

    // Reset in the middle of a BOS transmission.
    issue(3'd1, 8'h00);
    wait_trig(b);
    send_done();
    rx_send(8'h20);
    wait_resp(kind); check("crc2_resp", kind, 2'b10);
    tick();
    issue(3'd2, 8'h00);
    wait_trig(b); check("bos_rst_sig", b, 8'h40);
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_tx_en", tx_en, 1);
    check("mid_rst_tx_byte", tx_byte, 8'h00);
    check("mid_rst_granted", granted, 0);
    check("mid_rst_streaming", streaming, 0);
    check("mid_rst_flags", {done, error, rx_ack}, 3'b000);
    reset = 1'b1;
    tick();
    check("mid_rst_cmd_ready", cmd_ready, 1);
    t0 = n_trig;
    repeat (6) tick();
    check("mid_rst_no_trig", n_trig - t0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
